// File: rtl/piano_note_scheduler_if.sv
// Request, frame-sync and output bundle for the piano note scheduler.
// The slave side is the scheduler; the master side drives requests and observes the tone.
interface piano_note_scheduler_if;
    logic       iManReq;
    logic [3:0] iManNote;
    logic       iDemoReq;
    logic [3:0] iDemoNote;
    logic       iVertical_Sync;
    logic [1:0] oGrant;
    logic       oNoteValid;
    logic [3:0] oActiveNote;
    logic [3:0] oDispNote;
    logic       oDispValid;
    logic       oTone;

    modport master (
        output iManReq, iManNote, iDemoReq, iDemoNote, iVertical_Sync,
        input  oGrant, oNoteValid, oActiveNote, oDispNote, oDispValid, oTone
    );

    modport slave (
        input  iManReq, iManNote, iDemoReq, iDemoNote, iVertical_Sync,
        output oGrant, oNoteValid, oActiveNote, oDispNote, oDispValid, oTone
    );
endinterface

// File: rtl/piano_note_scheduler.sv
// Arbitrates a held manual key against a frame-timed demo note, drives the key renderer
// once per video frame and generates a square-wave tone for the sounding note.
module piano_note_scheduler #(
    parameter int unsigned HOLD_FRAMES = 15
) (
    input logic                   Clock,
    input logic                   Reset,
    piano_note_scheduler_if.slave bus_io
);
    localparam int unsigned FrameW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [FrameW-1:0] FrameLast = FrameW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StMan, StDemo} state_e;

    state_e            state_q, state_d;
    logic [3:0]        note_q, note_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic [1:0]        grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [3:0]        disp_note_q;
    logic              disp_valid_q;
    logic              vsync_q;
    logic [16:0]       cnt_q, cnt_d;
    logic              tone_q, tone_d;
    logic              tick;
    logic              man_ok, demo_ok;

    function automatic logic [16:0] half_period(input logic [3:0] note);
        case (note)
            4'd0:    half_period = 17'd95556;
            4'd1:    half_period = 17'd90193;
            4'd2:    half_period = 17'd85131;
            4'd3:    half_period = 17'd80353;
            4'd4:    half_period = 17'd75843;
            4'd5:    half_period = 17'd71586;
            4'd6:    half_period = 17'd67568;
            4'd7:    half_period = 17'd63776;
            4'd8:    half_period = 17'd60196;
            4'd9:    half_period = 17'd56818;
            4'd10:   half_period = 17'd53629;
            4'd11:   half_period = 17'd50619;
            default: half_period = 17'd95556;
        endcase
    endfunction

    assign tick    = vsync_q & ~bus_io.iVertical_Sync;
    assign man_ok  = bus_io.iManReq & (bus_io.iManNote < 4'd12);
    assign demo_ok = bus_io.iDemoReq & (bus_io.iDemoNote < 4'd12);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= StIdle;
            note_q       <= 4'd0;
            frame_q      <= '0;
            grant_q      <= 2'b00;
            valid_q      <= 1'b0;
            disp_note_q  <= 4'd0;
            disp_valid_q <= 1'b0;
            vsync_q      <= 1'b1;
            cnt_q        <= '0;
            tone_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            note_q  <= note_d;
            frame_q <= frame_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            vsync_q <= bus_io.iVertical_Sync;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            if (tick) begin
                disp_note_q  <= note_q;
                disp_valid_q <= valid_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        frame_d = frame_q;
        unique case (state_q)
            StIdle: begin
                if (man_ok) begin
                    state_d = StMan;
                    note_d  = bus_io.iManNote;
                end else if (demo_ok) begin
                    state_d = StDemo;
                    note_d  = bus_io.iDemoNote;
                    frame_d = '0;
                end
            end
            StMan: begin
                if (!bus_io.iManReq) begin
                    state_d = StIdle;
                end else if (man_ok) begin
                    note_d = bus_io.iManNote;
                end
            end
            StDemo: begin
                // Manual preemption discards the demo; a fresh demo pulse restarts the hold.
                if (man_ok) begin
                    state_d = StMan;
                    note_d  = bus_io.iManNote;
                end else if (demo_ok) begin
                    note_d  = bus_io.iDemoNote;
                    frame_d = '0;
                end else if (tick) begin
                    if (frame_q == FrameLast) begin
                        state_d = StIdle;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FrameW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_d = 2'b00;
        valid_d = 1'b0;
        unique case (state_d)
            StMan: begin
                grant_d = 2'b01;
                valid_d = 1'b1;
            end
            StDemo: begin
                grant_d = 2'b10;
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Reload with N-1 so consecutive toggles are exactly N cycles apart.
    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (!valid_d) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (!valid_q || (note_d != note_q)) begin
            cnt_d = half_period(note_d) - 17'd1;
        end else if (cnt_q == '0) begin
            tone_d = ~tone_q;
            cnt_d  = half_period(note_q) - 17'd1;
        end else begin
            cnt_d = cnt_q - 17'd1;
        end
    end

    assign bus_io.oGrant      = grant_q;
    assign bus_io.oNoteValid  = valid_q;
    assign bus_io.oActiveNote = note_q;
    assign bus_io.oDispNote   = disp_note_q;
    assign bus_io.oDispValid  = disp_valid_q;
    assign bus_io.oTone       = tone_q;
endmodule

// File: tb/tb_piano_note_scheduler.sv
// Scoreboard bench: a rule-level model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares them against the scheduler.
module tb_piano_note_scheduler;
    localparam int unsigned HOLD  = 15;
    localparam int          FRAME = 16;

    logic clk = 1'b0;
    logic rst;

    piano_note_scheduler_if bus ();

    piano_note_scheduler #(.HOLD_FRAMES(HOLD)) dut (
        .Clock  (clk),
        .Reset  (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] grant;
        logic       valid;
        logic [3:0] note;
        logic [3:0] dnote;
        logic       dvalid;
        logic       tone;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int rom[12] = '{95556, 90193, 85131, 80353, 75843, 71586,
                    67568, 63776, 60196, 56818, 53629, 50619};

    // Model: owner 0=none 1=manual 2=demo; frames_left counts remaining vsync edges.
    int m_owner, m_note, m_left, m_dnote, m_tleft;
    bit m_dvalid, m_prev_vs, m_tone;
    int vcnt = 0;

    task automatic model(input bit r, input bit mr, input int mn, input bit dr, input int dn,
                         input bit vs);
        bit   old_valid, tick, mv, dv;
        int   old_note;
        exp_t e;
        if (r) begin
            m_owner = 0; m_note = 0; m_left = 0; m_dnote = 0; m_dvalid = 0;
            m_prev_vs = 1; m_tone = 0; m_tleft = 0;
        end else begin
            old_valid = (m_owner != 0);
            old_note  = m_note;
            tick      = m_prev_vs && !vs;
            m_prev_vs = vs;
            if (tick) begin
                m_dnote  = m_note;
                m_dvalid = old_valid;
            end
            mv = mr && (mn < 12);
            dv = dr && (dn < 12);
            case (m_owner)
                0: if (mv) begin m_owner = 1; m_note = mn; end
                   else if (dv) begin m_owner = 2; m_note = dn; m_left = HOLD; end
                1: if (!mr) m_owner = 0;
                   else if (mn < 12) m_note = mn;
                default: if (mv) begin m_owner = 1; m_note = mn; end
                   else if (dv) begin m_note = dn; m_left = HOLD; end
                   else if (tick) begin
                       m_left--;
                       if (m_left == 0) m_owner = 0;
                   end
            endcase
            if (m_owner == 0) begin
                m_tone = 0; m_tleft = 0;
            end else if (!old_valid || m_note != old_note) begin
                m_tleft = rom[m_note];
            end else begin
                m_tleft--;
                if (m_tleft == 0) begin
                    m_tone  = !m_tone;
                    m_tleft = rom[m_note];
                end
            end
        end
        e.grant  = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
        e.valid  = (m_owner != 0);
        e.note   = 4'(m_note);
        e.dnote  = 4'(m_dnote);
        e.dvalid = m_dvalid;
        e.tone   = m_tone;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit mr, input logic [3:0] mn, input bit dr,
                        input logic [3:0] dn, input bit vs);
        rst                = r;
        bus.iManReq        = mr;
        bus.iManNote       = mn;
        bus.iDemoReq       = dr;
        bus.iDemoNote      = dn;
        bus.iVertical_Sync = vs;
        @(posedge clk);
        #1;
        model(r, mr, int'(mn), dr, int'(dn), vs);
    endtask

    function automatic bit next_vs();
        vcnt = (vcnt + 1) % FRAME;
        return (vcnt >= FRAME - 2) ? 1'b0 : 1'b1;
    endfunction

    task automatic run(input int n, input bit mr, input logic [3:0] mn);
        for (int i = 0; i < n; i++) step(1'b0, mr, mn, 1'b0, 4'd0, next_vs());
    endtask

    task automatic demo_pulse(input logic [3:0] dn);
        step(1'b0, 1'b0, 4'd0, 1'b1, dn, next_vs());
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.oGrant, bus.oNoteValid, bus.oActiveNote, bus.oDispNote, bus.oDispValid,
                 bus.oTone};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got grant=%b valid=%b note=%0d disp=%0d dvalid=%b tone=%b required grant=%b valid=%b note=%0d disp=%0d dvalid=%b tone=%b",
                         $time, a.grant, a.valid, a.note, a.dnote, a.dvalid, a.tone,
                         e.grant, e.valid, e.note, e.dnote, e.dvalid, e.tone);
            end
        end
    end

    initial begin
        bit       mr, dr, r;
        logic [3:0] mn, dn;
        rst = 1'b1;
        bus.iManReq = 0; bus.iManNote = 0; bus.iDemoReq = 0; bus.iDemoNote = 0;
        bus.iVertical_Sync = 1;
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

        // Held key 9: one full half-period toggle, then release drops the tone.
        for (int i = 0; i < 56830; i++) step(1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 1'b1);
        run(4, 1'b0, 4'd0);

        // Demo note 0 lasts HOLD frames then returns to idle.
        demo_pulse(4'd0);
        run(FRAME * (HOLD + 2), 1'b0, 4'd0);

        // Demo preempted by manual note 4; the demo must not come back.
        demo_pulse(4'd3);
        run(40, 1'b0, 4'd0);
        run(7, 1'b1, 4'd4);
        run(3, 1'b1, 4'd7);
        run(FRAME * (HOLD + 2), 1'b0, 4'd0);

        // Invalid manual note, then simultaneous manual and demo requests.
        run(5, 1'b1, 4'd13);
        step(1'b0, 1'b1, 4'd2, 1'b1, 4'd5, next_vs());
        run(5, 1'b1, 4'd2);
        run(3, 1'b0, 4'd0);

        // Reset during a demo while vsync is high.
        demo_pulse(4'd6);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);

        // Randomized traffic.
        mr = 0; mn = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) mr = !mr;
            if ($urandom_range(0, 19) == 0) mn = 4'($urandom_range(0, 15));
            dr = ($urandom_range(0, 79) == 0);
            dn = 4'($urandom_range(0, 15));
            r  = ($urandom_range(0, 999) == 0);
            step(r, mr, mn, dr, dn, next_vs());
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
